branch_issue_queue: RTL and testbench

- In-order issue buffer directly upstream of the branch execution unit (BEU).
- Holds decoded branch/jump instructions (JAL, JALR, Bxx) until both source operands are available, capturing them from the writeback broadcast.
- Issues the oldest entry to the BEU one per cycle.
- The BEU has no back-pressure, so issue is unconditional once the head entry is ready.

---
 rtl/branch_issue_queue.sv | 129 ++++++++++++
 tb/tb_branch_issue_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_issue_queue.sv
// branch_issue_queue: in-order branch issue buffer that captures operands from writeback and issues the oldest ready entry.
// Defining BIQ_ENQ_BYPASS_EN lets a fully ready instruction skip an empty queue and issue in its enqueue cycle.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif
module branch_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic                            enq_valid_i,
    output logic                            enq_ready_o,
    input  logic [63:0]                     enq_pc_i,
    input  logic [31:0]                     enq_inst_i,
    input  logic [`SCOREBOARD_SIZE_WIDTH:0] enq_sid_i,
    input  logic [3:0]                      enq_func_code_i,
    input  logic                            enq_rs1_ready_i,
    input  logic                            enq_rs2_ready_i,
    input  logic [63:0]                     enq_rs1_value_i,
    input  logic [63:0]                     enq_rs2_value_i,
    input  logic [`SCOREBOARD_SIZE_WIDTH:0] enq_rs1_tag_i,
    input  logic [`SCOREBOARD_SIZE_WIDTH:0] enq_rs2_tag_i,
    input  logic                            wb_valid_i,
    input  logic [`SCOREBOARD_SIZE_WIDTH:0] wb_sid_i,
    input  logic [63:0]                     wb_value_i,
    output logic                            branch_valid_o,
    output logic [63:0]                     branch_pc_o,
    output logic [31:0]                     branch_inst_o,
    output logic [`SCOREBOARD_SIZE_WIDTH:0] branch_sid_o,
    output logic [63:0]                     rs1_value_o,
    output logic [63:0]                     rs2_value_o,
    output logic [3:0]                      func_code_o
);
    localparam int SW = `SCOREBOARD_SIZE_WIDTH + 1;
    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];
    logic [DEPTH-1:0] v, r1, r2;
    logic [63:0]      pc_q [DEPTH];
    logic [63:0]      v1_q [DEPTH];
    logic [63:0]      v2_q [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [SW-1:0]    sid_q [DEPTH];
    logic [SW-1:0]    t1_q [DEPTH];
    logic [SW-1:0]    t2_q [DEPTH];
    logic [3:0]       fc_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             e_r1, e_r2, head_rdy, byp, wr_en;
    logic [63:0]      e_v1, e_v2;
    // An operand whose producer broadcasts in the enqueue cycle is captured as ready
    always_comb begin
        e_r1 = enq_rs1_ready_i | (wb_valid_i & (enq_rs1_tag_i == wb_sid_i));
        e_r2 = enq_rs2_ready_i | (wb_valid_i & (enq_rs2_tag_i == wb_sid_i));
        e_v1 = enq_rs1_ready_i ? enq_rs1_value_i : wb_value_i;
        e_v2 = enq_rs2_ready_i ? enq_rs2_value_i : wb_value_i;
        enq_ready_o = count != FULL;
        head_rdy = v[rd_ptr] & r1[rd_ptr] & r2[rd_ptr] & !flush_i;
`ifdef BIQ_ENQ_BYPASS_EN
        byp = (count == '0) & enq_valid_i & e_r1 & e_r2 & !flush_i;
`else
        byp = 1'b0;
`endif
        wr_en = enq_valid_i & enq_ready_o & !flush_i & !byp;
        branch_valid_o = head_rdy | byp;
        branch_pc_o = byp ? enq_pc_i : pc_q[rd_ptr];
        branch_inst_o = byp ? enq_inst_i : inst_q[rd_ptr];
        branch_sid_o = byp ? enq_sid_i : sid_q[rd_ptr];
        rs1_value_o = byp ? e_v1 : v1_q[rd_ptr];
        rs2_value_o = byp ? e_v2 : v2_q[rd_ptr];
        func_code_o = byp ? enq_func_code_i : fc_q[rd_ptr];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            r1 <= '0;
            r2 <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                v1_q[i] <= '0;
                v2_q[i] <= '0;
                inst_q[i] <= '0;
                sid_q[i] <= '0;
                t1_q[i] <= '0;
                t2_q[i] <= '0;
                fc_q[i] <= '0;
            end
        end else if (flush_i) begin
            v <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_valid_i && v[i] && !r1[i] && t1_q[i] == wb_sid_i) begin
                    r1[i] <= 1'b1;
                    v1_q[i] <= wb_value_i;
                end
                if (wb_valid_i && v[i] && !r2[i] && t2_q[i] == wb_sid_i) begin
                    r2[i] <= 1'b1;
                    v2_q[i] <= wb_value_i;
                end
            end
            if (head_rdy) begin
                v[rd_ptr] <= 1'b0;
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en) begin
                v[wr_ptr] <= 1'b1;
                pc_q[wr_ptr] <= enq_pc_i;
                inst_q[wr_ptr] <= enq_inst_i;
                sid_q[wr_ptr] <= enq_sid_i;
                fc_q[wr_ptr] <= enq_func_code_i;
                r1[wr_ptr] <= e_r1;
                r2[wr_ptr] <= e_r2;
                v1_q[wr_ptr] <= e_v1;
                v2_q[wr_ptr] <= e_v2;
                t1_q[wr_ptr] <= enq_rs1_tag_i;
                t2_q[wr_ptr] <= enq_rs2_tag_i;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= (wr_en && !head_rdy) ? count + (PTR_W+1)'(1) :
                     (!wr_en && head_rdy) ? count - (PTR_W+1)'(1) : count;
        end
    end
endmodule

// File: tb/tb_branch_issue_queue.sv
// tb_branch_issue_queue: directed self-checking bench for branch_issue_queue (default build, no enqueue bypass).
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif
module tb_branch_issue_queue;
    localparam int SW = `SCOREBOARD_SIZE_WIDTH + 1;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i, enq_valid_i, enq_ready_o;
    logic [63:0]   enq_pc_i, enq_rs1_value_i, enq_rs2_value_i, wb_value_i;
    logic [31:0]   enq_inst_i;
    logic [SW-1:0] enq_sid_i, enq_rs1_tag_i, enq_rs2_tag_i, wb_sid_i;
    logic [3:0]    enq_func_code_i;
    logic          enq_rs1_ready_i, enq_rs2_ready_i, wb_valid_i;
    logic          branch_valid_o;
    logic [63:0]   branch_pc_o, rs1_value_o, rs2_value_o;
    logic [31:0]   branch_inst_o;
    logic [SW-1:0] branch_sid_o;
    logic [3:0]    func_code_o;
    int            n_chk = 0;
    int            n_fail = 0;

    branch_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_inst_i(enq_inst_i), .enq_sid_i(enq_sid_i),
        .enq_func_code_i(enq_func_code_i),
        .enq_rs1_ready_i(enq_rs1_ready_i), .enq_rs2_ready_i(enq_rs2_ready_i),
        .enq_rs1_value_i(enq_rs1_value_i), .enq_rs2_value_i(enq_rs2_value_i),
        .enq_rs1_tag_i(enq_rs1_tag_i), .enq_rs2_tag_i(enq_rs2_tag_i),
        .wb_valid_i(wb_valid_i), .wb_sid_i(wb_sid_i), .wb_value_i(wb_value_i),
        .branch_valid_o(branch_valid_o), .branch_pc_o(branch_pc_o),
        .branch_inst_o(branch_inst_o), .branch_sid_o(branch_sid_o),
        .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
        .func_code_o(func_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush_i = 1'b0;
        enq_valid_i = 1'b0;
        enq_pc_i = '0;
        enq_inst_i = '0;
        enq_sid_i = '0;
        enq_func_code_i = '0;
        enq_rs1_ready_i = 1'b0;
        enq_rs2_ready_i = 1'b0;
        enq_rs1_value_i = '0;
        enq_rs2_value_i = '0;
        enq_rs1_tag_i = '0;
        enq_rs2_tag_i = '0;
        wb_valid_i = 1'b0;
        wb_sid_i = '0;
        wb_value_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic enq(input int pc, input int sid, input int fc,
                       input int r1, input int v1, input int t1,
                       input int r2, input int v2, input int t2);
        enq_valid_i = 1'b1;
        enq_pc_i = 64'(pc);
        enq_inst_i = 32'hC0DE_0000 | 32'(sid);
        enq_sid_i = SW'(sid);
        enq_func_code_i = 4'(fc);
        enq_rs1_ready_i = (r1 != 0);
        enq_rs1_value_i = 64'(v1);
        enq_rs1_tag_i = SW'(t1);
        enq_rs2_ready_i = (r2 != 0);
        enq_rs2_value_i = 64'(v2);
        enq_rs2_tag_i = SW'(t2);
    endtask

    task automatic wb(input int sid, input int val);
        wb_valid_i = 1'b1;
        wb_sid_i = SW'(sid);
        wb_value_i = 64'(val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #2;
        chk("rst_valid", 64'(branch_valid_o), 64'h0);
        chk("rst_ready", 64'(enq_ready_o), 64'h1);
        chk("rst_pc", branch_pc_o, 64'h0);
        chk("rst_sid", 64'(branch_sid_o), 64'h0);
        #10 rst_n = 1'b1;
        // JAL, both operands ready: issues one cycle after enqueue
        tick(); enq('h1000, 3, 'b0111, 1, 'hA, 0, 1, 'hB, 0); #1;
        chk("jal_no_bypass", 64'(branch_valid_o), 64'h0);
        tick(); #1;
        chk("jal_valid", 64'(branch_valid_o), 64'h1);
        chk("jal_pc", branch_pc_o, 64'h1000);
        chk("jal_sid", 64'(branch_sid_o), 64'h3);
        chk("jal_fc", 64'(func_code_o), 64'h7);
        chk("jal_inst", 64'(branch_inst_o), 64'hC0DE0003);
        chk("jal_rs1", rs1_value_o, 64'hA);
        chk("jal_rs2", rs2_value_o, 64'hB);
        tick(); #1;
        chk("jal_empty", 64'(branch_valid_o), 64'h0);
        chk("jal_ready", 64'(enq_ready_o), 64'h1);
        // BEQ waits on tag 2, woken two cycles after enqueue
        tick(); enq('h2000, 5, 'b0100, 0, 0, 2, 1, 'h22, 0); #1;
        tick(); #1;
        chk("beq_wait", 64'(branch_valid_o), 64'h0);
        tick(); wb(2, 'h55); #1;
        chk("beq_wake_cycle", 64'(branch_valid_o), 64'h0);
        tick(); #1;
        chk("beq_valid", 64'(branch_valid_o), 64'h1);
        chk("beq_rs1", rs1_value_o, 64'h55);
        chk("beq_rs2", rs2_value_o, 64'h22);
        chk("beq_sid", 64'(branch_sid_o), 64'h5);
        tick(); #1;
        chk("beq_empty", 64'(branch_valid_o), 64'h0);
        // Fill with blocked head, offer a fifth, then wake the head
        for (int k = 0; k < 4; k++) begin
            tick(); enq('h3000 + 4 * k, 8 + k, 'b0100, (k != 0) ? 1 : 0, 'h30 + k, 6, 1, 0, 0); #1;
        end
        tick(); enq('h3100, 12, 'b0100, 1, 'h3C, 0, 1, 0, 0); #1;
        chk("full_ready", 64'(enq_ready_o), 64'h0);
        chk("full_blocked", 64'(branch_valid_o), 64'h0);
        tick(); wb(6, 'h66); #1;
        chk("full_ready_wb", 64'(enq_ready_o), 64'h0);
        tick(); #1;
        chk("full_head_valid", 64'(branch_valid_o), 64'h1);
        chk("full_head_sid", 64'(branch_sid_o), 64'h8);
        chk("full_head_rs1", rs1_value_o, 64'h66);
        chk("full_ready_issue", 64'(enq_ready_o), 64'h0);
        tick(); #1;
        chk("full_ready_after", 64'(enq_ready_o), 64'h1);
        chk("full_sid9", 64'(branch_sid_o), 64'h9);
        tick(); #1;
        chk("full_sid10", 64'(branch_sid_o), 64'hA);
        tick(); #1;
        chk("full_sid11", 64'(branch_sid_o), 64'hB);
        chk("full_sid11_valid", 64'(branch_valid_o), 64'h1);
        tick(); #1;
        chk("full_fifth_dropped", 64'(branch_valid_o), 64'h0);
        // Blocked head holds back a ready younger entry
        tick(); enq('h4000, 13, 'b0100, 0, 0, 7, 1, 2, 0); #1;
        tick(); enq('h4004, 14, 'b0100, 1, 'h41, 0, 1, 'h42, 0); #1;
        chk("order_blocked", 64'(branch_valid_o), 64'h0);
        tick(); wb(7, 'h77); #1;
        chk("order_wake_cycle", 64'(branch_valid_o), 64'h0);
        tick(); #1;
        chk("order_first_sid", 64'(branch_sid_o), 64'hD);
        chk("order_first_rs1", rs1_value_o, 64'h77);
        tick(); #1;
        chk("order_second_valid", 64'(branch_valid_o), 64'h1);
        chk("order_second_sid", 64'(branch_sid_o), 64'hE);
        chk("order_second_rs1", rs1_value_o, 64'h41);
        tick(); #1;
        chk("order_empty", 64'(branch_valid_o), 64'h0);
        // Enqueue colliding with its producer's writeback
        tick(); enq('h5000, 15, 'b0101, 0, 0, 4, 1, 5, 0); wb(4, 'hABCD); #1;
        chk("coll_enq_cycle", 64'(branch_valid_o), 64'h0);
        tick(); #1;
        chk("coll_valid", 64'(branch_valid_o), 64'h1);
        chk("coll_rs1", rs1_value_o, 64'hABCD);
        chk("coll_sid", 64'(branch_sid_o), 64'hF);
        tick(); #1;
        chk("coll_empty", 64'(branch_valid_o), 64'h0);
        // Both operands woken by one broadcast
        tick(); enq('h6000, 16, 'b0100, 0, 0, 9, 0, 0, 9); #1;
        tick(); wb(9, 'h99); #1;
        tick(); #1;
        chk("dual_valid", 64'(branch_valid_o), 64'h1);
        chk("dual_rs1", rs1_value_o, 64'h99);
        chk("dual_rs2", rs2_value_o, 64'h99);
        tick(); #1;
        chk("dual_empty", 64'(branch_valid_o), 64'h0);
        // Flush with a ready head and a simultaneous enqueue
        tick(); enq('h7000, 17, 'b0100, 0, 0, 1, 1, 0, 0); #1;
        tick(); enq('h7004, 18, 'b0100, 1, 0, 0, 1, 0, 0); #1;
        tick(); enq('h7008, 19, 'b0100, 1, 0, 0, 1, 0, 0); wb(1, 'h11); #1;
        chk("flush_pre", 64'(branch_valid_o), 64'h0);
        tick(); flush_i = 1'b1; enq('h7100, 20, 'b0111, 1, 0, 0, 1, 0, 0); #1;
        chk("flush_cycle", 64'(branch_valid_o), 64'h0);
        tick(); #1;
        chk("flush_after_valid", 64'(branch_valid_o), 64'h0);
        chk("flush_after_ready", 64'(enq_ready_o), 64'h1);
        tick(); #1;
        chk("flush_dropped", 64'(branch_valid_o), 64'h0);
        tick(); enq('h7200, 21, 'b0111, 1, 0, 0, 1, 0, 0); #1;
        tick(); #1;
        chk("post_flush_valid", 64'(branch_valid_o), 64'h1);
        chk("post_flush_sid", 64'(branch_sid_o), 64'h15);
        chk("post_flush_pc", branch_pc_o, 64'h7200);
        tick(); #1;
        chk("post_flush_empty", 64'(branch_valid_o), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
